// File: rtl/debug_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debug_pkg
// Description : Shared debug encodings: dump FSM states, command codes, sizing
// Revision    : 1.0 - initial release
// ============================================================================
package debug_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_STEP     = 3'd1,
        ST_SET_ADDR = 3'd2,
        ST_CAPTURE  = 3'd3,
        ST_SEND     = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    localparam int NB_DEFAULT      = 32;
    localparam int BYTE_NB_DEFAULT = 8;
    localparam int BYTES_PER_REG   = NB_DEFAULT / BYTE_NB_DEFAULT;

    // Command bytes decoded upstream by the debug command decoder
    localparam logic [7:0] c_CMD_STEP = 8'h73;
    localparam logic [7:0] c_CMD_DUMP = 8'h64;

    function automatic int bytes_per_reg(input int nb, input int byte_nb);
        return nb / byte_nb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debug_reg_dump_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : debug_reg_dump_ctrl_if
// Description : Command, register-file debug port and TX byte stream bundle
// Revision    : 1.0 - initial release
// ============================================================================
interface debug_reg_dump_ctrl_if #(
    parameter int NB      = 32,
    parameter int REGS    = 5,
    parameter int BYTE_NB = 8
);
    logic                i_step_req;
    logic                i_dump_req;
    logic [NB-1:0]       i_mips_register_data;
    logic [REGS-1:0]     o_mips_register_number;
    logic                o_step;
    logic [BYTE_NB-1:0]  o_tx_data;
    logic                o_tx_valid;
    logic                i_tx_ready;
    logic                o_busy;
    logic                o_dump_done;

    modport slave (
        input  i_step_req, i_dump_req, i_mips_register_data, i_tx_ready,
        output o_mips_register_number, o_step, o_tx_data, o_tx_valid,
               o_busy, o_dump_done
    );

    modport master (
        output i_step_req, i_dump_req, i_mips_register_data, i_tx_ready,
        input  o_mips_register_number, o_step, o_tx_data, o_tx_valid,
               o_busy, o_dump_done
    );
endinterface
`default_nettype wire

// File: rtl/word_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module      : word_byte_serializer
// Description : Loads an NB-bit word and shifts it out MSB byte first
// Revision    : 1.0 - initial release
// ============================================================================
module word_byte_serializer
    import debug_pkg::*;
#(
    parameter int NB      = 32,
    parameter int BYTE_NB = 8
) (
    input  wire logic               i_clk,
    input  wire logic               i_reset,
    input  wire logic               i_load,
    input  wire logic [NB-1:0]      i_word,
    input  wire logic               i_shift,
    output logic      [BYTE_NB-1:0] o_byte,
    output logic                    o_last
);
    localparam int c_BYTES = bytes_per_reg(NB, BYTE_NB);
    localparam int c_CNT_W = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;

    logic [NB-1:0]      r_shift;
    logic [c_CNT_W-1:0] r_byte_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
        end else if (i_load) begin
            r_shift    <= i_word;
            r_byte_cnt <= '0;
        end else if (i_shift) begin
            r_shift    <= r_shift << BYTE_NB;
            r_byte_cnt <= r_byte_cnt + 1'b1;
        end
    end

    assign o_byte = r_shift[NB-1 -: BYTE_NB];
    assign o_last = (r_byte_cnt == c_CNT_W'(c_BYTES - 1));

endmodule
`default_nettype wire

// File: rtl/debug_reg_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : debug_reg_dump_ctrl
// Description : Pipeline step strobe and full register-file dump over a byte stream
// Revision    : 1.0 - initial release
// ============================================================================
module debug_reg_dump_ctrl
    import debug_pkg::*;
#(
    parameter int NB       = 32,
    parameter int REGS     = 5,
    parameter int NUM_REGS = 32,
    parameter int BYTE_NB  = 8
) (
    input  wire logic            i_clk,
    input  wire logic            i_reset,
    debug_reg_dump_ctrl_if.slave bus
);
    state_t             r_state;
    state_t             w_next_state;
    logic [REGS-1:0]    r_idx;
    logic               r_dump_pending;
    logic               w_load;
    logic               w_shift;
    logic               w_last;
    logic               w_xfer;
    logic [BYTE_NB-1:0] w_byte;

    assign w_xfer = (r_state == ST_SEND) && bus.i_tx_ready;

    word_byte_serializer #(
        .NB      (NB),
        .BYTE_NB (BYTE_NB)
    ) u_serializer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (w_load),
        .i_word  (bus.i_mips_register_data),
        .i_shift (w_shift),
        .o_byte  (w_byte),
        .o_last  (w_last)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= ST_IDLE;
            r_idx          <= '0;
            r_dump_pending <= 1'b0;
        end else begin
            r_state <= w_next_state;
            // A dump requested together with a step runs right after the step
            if (r_state == ST_IDLE && bus.i_step_req && bus.i_dump_req)
                r_dump_pending <= 1'b1;
            else if (r_state == ST_STEP)
                r_dump_pending <= 1'b0;
            if (w_xfer && w_last && r_idx != REGS'(NUM_REGS - 1))
                r_idx <= r_idx + 1'b1;
            else if (r_state == ST_DONE)
                r_idx <= '0;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_step_req)
                    w_next_state = ST_STEP;
                else if (bus.i_dump_req)
                    w_next_state = ST_SET_ADDR;
            end
            ST_STEP:     w_next_state = r_dump_pending ? ST_SET_ADDR : ST_IDLE;
            ST_SET_ADDR: w_next_state = ST_CAPTURE;
            ST_CAPTURE: begin
                w_load       = 1'b1;
                w_next_state = ST_SEND;
            end
            ST_SEND: begin
                w_shift = bus.i_tx_ready;
                if (w_xfer && w_last)
                    w_next_state = (r_idx == REGS'(NUM_REGS - 1)) ? ST_DONE : ST_SET_ADDR;
            end
            ST_DONE:     w_next_state = ST_IDLE;
            default:     w_next_state = ST_IDLE;
        endcase
    end

    assign bus.o_mips_register_number = r_idx;
    assign bus.o_step                 = (r_state == ST_STEP);
    assign bus.o_tx_valid             = (r_state == ST_SEND);
    assign bus.o_tx_data              = (r_state == ST_SEND) ? w_byte : '0;
    assign bus.o_busy                 = (r_state != ST_IDLE);
    assign bus.o_dump_done            = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_debug_reg_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_debug_reg_dump_ctrl
// Description : Self-checking bench: step strobe, dump stream, backpressure, reset abort
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debug_reg_dump_ctrl;

    localparam int NB       = 32;
    localparam int REGS     = 5;
    localparam int NUM_REGS = 32;
    localparam int BYTE_NB  = 8;
    localparam int N_BYTES  = NUM_REGS * NB / BYTE_NB;

    typedef struct {
        int         idx;
        logic [7:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    debug_reg_dump_ctrl_if #(.NB(NB), .REGS(REGS), .BYTE_NB(BYTE_NB)) bus ();

    debug_reg_dump_ctrl #(
        .NB       (NB),
        .REGS     (REGS),
        .NUM_REGS (NUM_REGS),
        .BYTE_NB  (BYTE_NB)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    logic [31:0] regfile [NUM_REGS];
    assign bus.i_mips_register_data =
        (bus.o_mips_register_number == '0) ? 32'h0 : regfile[bus.o_mips_register_number];

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor state, sampled on the falling edge
    int         edge_cnt   = 0;
    int         done_cnt   = 0;
    int         done_edge  = 0;
    int         done_bytes = 0;
    int         step_cnt   = 0;
    int         step_edge  = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h0;
    logic [7:0] q_byte [$];
    logic [4:0] q_reg  [$];

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(bus.o_tx_valid), 32'd1);
                check("hold_data", 32'(bus.o_tx_data), 32'(prev_data));
            end
            prev_stall <= bus.o_tx_valid && !bus.i_tx_ready;
            prev_data  <= bus.o_tx_data;
            if (bus.o_tx_valid && bus.i_tx_ready) begin
                q_byte.push_back(bus.o_tx_data);
                q_reg.push_back(bus.o_mips_register_number);
            end
            if (bus.o_dump_done) begin
                done_cnt   <= done_cnt + 1;
                done_edge  <= edge_cnt;
                done_bytes <= q_byte.size();
            end
            if (bus.o_step) begin
                step_cnt  <= step_cnt + 1;
                step_edge <= edge_cnt;
            end
        end
    end

    // Stimulus: ready_mode 0 = low, 1 = high, 2 = random ~30% high
    int ready_mode = 0;
    int e0         = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        case (ready_mode)
            1:       bus.i_tx_ready = 1'b1;
            2:       bus.i_tx_ready = ($urandom_range(0, 9) < 3);
            default: bus.i_tx_ready = 1'b0;
        endcase
    endtask

    task automatic pulse(input logic s, input logic d);
        tick();
        bus.i_step_req = s;
        bus.i_dump_req = d;
        tick();
        e0             = edge_cnt;
        bus.i_step_req = 1'b0;
        bus.i_dump_req = 1'b0;
    endtask

    task automatic wait_done(input int start_cnt, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (done_cnt > start_cnt) return;
        end
        check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_bytes(input int n, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (q_byte.size() >= n) return;
        end
        check("byte_timeout", 32'(q_byte.size()), 32'(n));
    endtask

    // Reference: every register, MSB byte first, register 0 reads as zero
    task automatic check_stream(input string tag);
        logic [31:0] word;
        logic [7:0]  exp_b;
        check({tag, "_count"}, 32'(q_byte.size()), 32'(N_BYTES));
        for (int i = 0; i < N_BYTES && i < q_byte.size(); i++) begin
            word  = (i / 4 == 0) ? 32'h0 : regfile[i / 4];
            exp_b = 8'((word >> (8 * (3 - (i % 4)))) & 32'hFF);
            check({tag, "_byte"}, 32'(q_byte[i]), 32'(exp_b));
            check({tag, "_regnum"}, 32'(q_reg[i]), 32'(i / 4));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_step"},   32'(bus.o_step), 32'd0);
        check({tag, "_valid"},  32'(bus.o_tx_valid), 32'd0);
        check({tag, "_data"},   32'(bus.o_tx_data), 32'd0);
        check({tag, "_busy"},   32'(bus.o_busy), 32'd0);
        check({tag, "_done"},   32'(bus.o_dump_done), 32'd0);
        check({tag, "_regnum"}, 32'(bus.o_mips_register_number), 32'd0);
    endtask

    task automatic default_regs();
        for (int i = 0; i < NUM_REGS; i++) regfile[i] = 32'h1000_0000 + 32'(i);
        regfile[5] = 32'h1234_5678;
    endtask

    vec_t tbl [12];

    initial begin
        int d0;
        int s0;
        tbl[0]  = '{0, 8'h00};   tbl[1]  = '{1, 8'h00};
        tbl[2]  = '{2, 8'h00};   tbl[3]  = '{3, 8'h00};
        tbl[4]  = '{4, 8'h10};   tbl[5]  = '{7, 8'h01};
        tbl[6]  = '{20, 8'h12};  tbl[7]  = '{21, 8'h34};
        tbl[8]  = '{22, 8'h56};  tbl[9]  = '{23, 8'h78};
        tbl[10] = '{124, 8'h10}; tbl[11] = '{127, 8'h1F};

        default_regs();
        bus.i_step_req = 1'b0;
        bus.i_dump_req = 1'b0;
        bus.i_tx_ready = 1'b0;

        // Reset with requests idle
        rst = 1'b1;
        repeat (3) tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // Single step
        s0 = step_cnt;
        pulse(1'b1, 1'b0);
        check("step_high", 32'(bus.o_step), 32'd1);
        check("step_busy", 32'(bus.o_busy), 32'd1);
        check("step_novalid", 32'(bus.o_tx_valid), 32'd0);
        tick();
        check("step_low", 32'(bus.o_step), 32'd0);
        check("step_busy_low", 32'(bus.o_busy), 32'd0);
        check("step_count", 32'(step_cnt - s0), 32'd1);

        // Full dump, ready always high
        ready_mode = 1;
        q_byte.delete(); q_reg.delete();
        d0 = done_cnt;
        pulse(1'b0, 1'b1);
        wait_done(d0, 400);
        check("dump_latency", 32'(done_edge - e0), 32'd192);
        check("dump_done_bytes", 32'(done_bytes), 32'(N_BYTES));
        check_stream("dump");
        for (int i = 0; i < 12; i++)
            if (tbl[i].idx < q_byte.size())
                check("table_byte", 32'(q_byte[tbl[i].idx]), 32'(tbl[i].exp));
            else
                check("table_missing", 32'(q_byte.size()), 32'(tbl[i].idx + 1));

        // Backpressure
        ready_mode = 2;
        q_byte.delete(); q_reg.delete();
        d0 = done_cnt;
        pulse(1'b0, 1'b1);
        wait_done(d0, 3000);
        check("bp_done_bytes", 32'(done_bytes), 32'(N_BYTES));
        check_stream("bp");

        // Step and dump in the same cycle
        ready_mode = 1;
        q_byte.delete(); q_reg.delete();
        d0 = done_cnt;
        s0 = step_cnt;
        pulse(1'b1, 1'b1);
        wait_done(d0, 400);
        check("combo_step_count", 32'(step_cnt - s0), 32'd1);
        check("combo_step_edge", 32'(step_edge - e0), 32'd0);
        check("combo_latency", 32'(done_edge - e0), 32'd193);
        check_stream("combo");

        // Requests while busy are dropped
        q_byte.delete(); q_reg.delete();
        d0 = done_cnt;
        s0 = step_cnt;
        pulse(1'b0, 1'b1);
        wait_bytes(41, 400);
        bus.i_step_req = 1'b1;
        bus.i_dump_req = 1'b1;
        tick();
        bus.i_step_req = 1'b0;
        bus.i_dump_req = 1'b0;
        wait_done(d0, 400);
        repeat (20) tick();
        check("busy_no_step", 32'(step_cnt - s0), 32'd0);
        check("busy_one_done", 32'(done_cnt - d0), 32'd1);
        check("busy_idle_after", 32'(bus.o_busy), 32'd0);
        check_stream("busy");

        // Reset during register 7, byte 2
        q_byte.delete(); q_reg.delete();
        pulse(1'b0, 1'b1);
        wait_bytes(30, 400);
        check("abort_point_reg", 32'(bus.o_mips_register_number), 32'd7);
        rst        = 1'b1;
        ready_mode = 0;
        bus.i_tx_ready = 1'b0;
        tick();
        check_idle_outputs("abort");
        rst = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) regfile[i] = $urandom;
        ready_mode = 2;
        q_byte.delete(); q_reg.delete();
        d0 = done_cnt;
        pulse(1'b0, 1'b1);
        wait_done(d0, 3000);
        check("restart_done_bytes", 32'(done_bytes), 32'(N_BYTES));
        check_stream("restart");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/debug_reg_dump_ctrl.md
Name: debug_reg_dump_ctrl

Overview:
Debug-side controller that sequences the decode stage's register file debug read port and the pipeline step strobe. On command it issues a single-cycle step pulse to the pipeline, or walks all MIPS registers through the debug read port. For each register it serializes the 32-bit value into bytes on a valid/ready stream toward the UART TX path. It sits between the debug command decoder and the decode stage (register-number input, register-data output, step input).

Parameters:
NB, 32, register data width; must be a multiple of BYTE_NB
REGS, 5, register-number width
NUM_REGS, 32, number of registers dumped (indices 0..NUM_REGS-1), NUM_REGS <= 2**REGS
BYTE_NB, 8, stream byte width

Ports:
i_clk  in  1  clock
i_reset  in  1  reset; synchronous, active-high
i_step_req  in  1  one-cycle request: advance pipeline one step
i_dump_req  in  1  one-cycle request: dump whole register file
i_mips_register_data  in  NB  data from register file debug read port (combinational read)
o_mips_register_number  out  REGS  register index driven to debug read port
o_step  out  1  one-cycle step strobe to pipeline
o_tx_data  out  BYTE_NB  byte to TX
o_tx_valid  out  1  o_tx_data valid
i_tx_ready  in  1  TX accepts byte; transfer = o_tx_valid && i_tx_ready on a rising edge
o_busy  out  1  high whenever state != IDLE
o_dump_done  out  1  one-cycle pulse after the last byte of the last register transfers

Behaviour:
- One clock domain. Reset is synchronous and active-high and is sampled on i_clk. State goes to IDLE; idx=0; byte_cnt=0; shift register=0; dump_pending=0. All outputs are 0.
- States: IDLE, STEP, SET_ADDR, CAPTURE, SEND, DONE.
- IDLE:
  - i_step_req -> STEP. Step has priority.
  - If i_dump_req is high in the same cycle, set dump_pending=1.
  - Else i_dump_req -> SET_ADDR.
- STEP:
  - o_step=1 for exactly this one cycle.
  - Next state is SET_ADDR if dump_pending (pending is cleared), else IDLE.
- SET_ADDR: o_mips_register_number=idx for one settle cycle. The port holds idx for the entire dump and is 0 in IDLE.
- CAPTURE: shift <= i_mips_register_data; byte_cnt <= 0; go to SEND.
- SEND:
  - o_tx_valid=1 and o_tx_data=shift[NB-1 -: BYTE_NB], i.e. MSB byte first.
  - On transfer: shift <<= BYTE_NB; byte_cnt++.
  - Without a transfer, o_tx_data and o_tx_valid hold stable.
  - After the transfer of byte NB/BYTE_NB-1:
    - If idx==NUM_REGS-1 -> DONE.
    - Else idx++ -> SET_ADDR.
- DONE: o_dump_done=1 for one cycle; idx <= 0; go to IDLE.
- i_step_req and i_dump_req arriving while o_busy=1 are dropped; no queueing except the STEP+dump case above.
- Latency with i_tx_ready constantly high:
  - Dump request sampled at edge E0: SET_ADDR runs in cycle 1, CAPTURE in cycle 2, first valid byte in cycle 3.
  - Each register costs 2 + NB/BYTE_NB cycles, i.e. 6 at the defaults.
  - o_dump_done is asserted in cycle 1 + 6*NUM_REGS = 193.
- Reset mid-dump aborts at the next edge. There is no partial-byte completion; o_tx_valid drops immediately after that edge.
- Register 0 is dumped like any other index (it reads 0 from the file).

Decomposition:
- Shared package debug_pkg:
  - State encoding localparams: ST_IDLE..ST_DONE, 3 bits.
  - BYTES_PER_REG = NB/BYTE_NB.
  - Command codes are shared with the debug command decoder.
- One natural sub-module, word_byte_serializer. It holds the NB-bit load, the valid/ready byte shift-out and byte_cnt, and raises a last-byte flag. The FSM in debug_reg_dump_ctrl drives its load and consumes that flag.

Test Plan:
1. Reset with reqs idle -> all outputs 0. Then i_step_req pulse -> o_step high for exactly 1 cycle, 1 cycle after the request; o_busy high for that cycle only; no tx activity.
2. Register-file model r[i]=0x10000000+i, r[5]=0x12345678, i_tx_ready=1, i_dump_req pulse:
   - 128 bytes are sent.
   - Bytes 20..23 are 12 34 56 78; bytes 0..3 are 00 00 00 00 (r0 forced 0).
   - o_mips_register_number steps 0..31.
   - o_dump_done pulses in cycle 193.
3. Backpressure: i_tx_ready random (about 30% high) -> byte stream is identical to scenario 2. o_tx_data never changes while valid && !ready. o_dump_done only after the 128th transfer.
4. i_step_req and i_dump_req in the same cycle -> o_step pulse first, then the dump starts in the next cycle; the full 128-byte stream is correct.
5. i_step_req and i_dump_req pulsed mid-dump (idx=10) -> no o_step pulse; no second dump; the stream is unaltered.
6. i_reset asserted during SEND of register 7, byte 2 -> next cycle all outputs 0 and state IDLE. A new i_dump_req restarts from register 0, byte 0.
